// File: rtl/wm_plant_model.sv
// Washing-machine plant model: water level, detergent dispenser, wash/spin timers
// and a sticky fault flag for illegal command combinations, all paced by a tick prescaler.
module wm_plant_model #(
    parameter int LEVEL_FULL  = 8,
    parameter int DET_TICKS   = 3,
    parameter int CYCLE_TICKS = 10,
    parameter int SPIN_TICKS  = 6,
    parameter int TICK_DIV    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       door_lock,
    input  logic       motor_on,
    input  logic       fill_value_on,
    input  logic       drain_value_on,
    input  logic       soap_wash,
    output logic       filled,
    output logic       drained,
    output logic       detergent_added,
    output logic       cycle_timeout,
    output logic       spin_timeout,
    output logic [7:0] level,
    output logic       fault
);

    localparam logic [7:0] LVL_FULL = 8'(LEVEL_FULL);
    localparam logic [7:0] DET_MAX  = 8'(DET_TICKS);
    localparam logic [7:0] CYC_MAX  = 8'(CYCLE_TICKS);
    localparam logic [7:0] SPN_MAX  = 8'(SPIN_TICKS);
    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    logic [7:0] prescaler;
    logic [7:0] det_cnt;
    logic [7:0] cyc_cnt;
    logic [7:0] spn_cnt;
    logic       dispensed;
    logic       tick;
    logic       spin_en;

    assign tick            = (prescaler == DIV_LAST);
    assign filled          = (level == LVL_FULL);
    assign drained         = (level == 8'd0);
    assign detergent_added = dispensed;
    assign cycle_timeout   = (cyc_cnt == CYC_MAX);
    assign spin_timeout    = (spn_cnt == SPN_MAX);
    assign spin_en         = drain_value_on && drained;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= 8'd0;
        end else if (tick) begin
            prescaler <= 8'd0;
        end else begin
            prescaler <= prescaler + 8'd1;
        end
    end

    // Opposing valve commands cancel each other out.
    always_ff @(posedge clk) begin
        if (reset) begin
            level <= 8'd0;
        end else if (tick) begin
            if (fill_value_on && !drain_value_on && level < LVL_FULL) begin
                level <= level + 8'd1;
            end else if (drain_value_on && !fill_value_on && level != 8'd0) begin
                level <= level - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !soap_wash) begin
            det_cnt   <= 8'd0;
            dispensed <= 1'b0;
        end else if (tick && filled && !dispensed) begin
            if (det_cnt + 8'd1 == DET_MAX) begin
                dispensed <= 1'b1;
                det_cnt   <= 8'd0;
            end else begin
                det_cnt <= det_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !motor_on) begin
            cyc_cnt <= 8'd0;
        end else if (tick && cyc_cnt < CYC_MAX) begin
            cyc_cnt <= cyc_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !spin_en) begin
            spn_cnt <= 8'd0;
        end else if (tick && spn_cnt < SPN_MAX) begin
            spn_cnt <= spn_cnt + 8'd1;
        end
    end

    // Sticky until reset; purely observational.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault <= 1'b0;
        end else if ((fill_value_on && drain_value_on) || (motor_on && !door_lock)) begin
            fault <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wm_plant_model.sv
// Directed testbench for wm_plant_model: default-parameter instance plus a TICK_DIV=4 instance.
module tb_wm_plant_model;

    logic       clk = 1'b0;
    logic       reset;
    logic       door_lock, motor_on, fill_value_on, drain_value_on, soap_wash;
    logic       filled, drained, detergent_added, cycle_timeout, spin_timeout, fault;
    logic [7:0] level;

    logic       d4_fill;
    logic       d4_filled, d4_drained, d4_det, d4_cyc, d4_spin, d4_fault;
    logic [7:0] d4_level;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    wm_plant_model u_dut (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .fill_value_on(fill_value_on), .drain_value_on(drain_value_on), .soap_wash(soap_wash),
        .filled(filled), .drained(drained), .detergent_added(detergent_added),
        .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .level(level), .fault(fault)
    );

    wm_plant_model #(.TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(reset), .door_lock(1'b1), .motor_on(1'b0),
        .fill_value_on(d4_fill), .drain_value_on(1'b0), .soap_wash(1'b0),
        .filled(d4_filled), .drained(d4_drained), .detergent_added(d4_det),
        .cycle_timeout(d4_cyc), .spin_timeout(d4_spin), .level(d4_level), .fault(d4_fault)
    );

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic lock, input logic motor,
                                 input logic fill, input logic drain, input logic soap);
        reset          = rst;
        door_lock      = lock;
        motor_on       = motor;
        fill_value_on  = fill;
        drain_value_on = drain;
        soap_wash      = soap;
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        d4_fill = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_level",   level, 8'd0);
        checkOutput("rst_filled",  {7'd0, filled}, 8'd0);
        checkOutput("rst_drained", {7'd0, drained}, 8'd1);
        checkOutput("rst_det",     {7'd0, detergent_added}, 8'd0);
        checkOutput("rst_cyc",     {7'd0, cycle_timeout}, 8'd0);
        checkOutput("rst_spin",    {7'd0, spin_timeout}, 8'd0);
        checkOutput("rst_fault",   {7'd0, fault}, 8'd0);

        applyStimulus(0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checkOutput($sformatf("fill_level_%0d", i), level, 8'(i));
            checkOutput($sformatf("fill_drained_%0d", i), {7'd0, drained}, 8'd0);
            checkOutput($sformatf("fill_filled_%0d", i), {7'd0, filled}, (i == 8) ? 8'd1 : 8'd0);
        end
        step(2);
        checkOutput("fill_sat_level", level, 8'd8);
        checkOutput("fill_sat_filled", {7'd0, filled}, 8'd1);

        applyStimulus(0, 0, 0, 0, 0, 1);
        step(2);
        checkOutput("det_before", {7'd0, detergent_added}, 8'd0);
        step(1);
        checkOutput("det_set", {7'd0, detergent_added}, 8'd1);
        step(3);
        checkOutput("det_hold", {7'd0, detergent_added}, 8'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        step(1);
        checkOutput("det_clear", {7'd0, detergent_added}, 8'd0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        step(2);
        checkOutput("det_again_before", {7'd0, detergent_added}, 8'd0);
        step(1);
        checkOutput("det_again_set", {7'd0, detergent_added}, 8'd1);

        applyStimulus(0, 1, 1, 0, 0, 0);
        step(9);
        checkOutput("cyc_before", {7'd0, cycle_timeout}, 8'd0);
        step(1);
        checkOutput("cyc_set", {7'd0, cycle_timeout}, 8'd1);
        step(3);
        checkOutput("cyc_sat", {7'd0, cycle_timeout}, 8'd1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        step(1);
        checkOutput("cyc_clear", {7'd0, cycle_timeout}, 8'd0);
        applyStimulus(0, 1, 1, 0, 0, 0);
        step(9);
        checkOutput("cyc_again_before", {7'd0, cycle_timeout}, 8'd0);
        step(1);
        checkOutput("cyc_again_set", {7'd0, cycle_timeout}, 8'd1);

        applyStimulus(0, 1, 0, 0, 1, 0);
        step(7);
        checkOutput("drain_level_1", level, 8'd1);
        checkOutput("drain_not_yet", {7'd0, drained}, 8'd0);
        step(1);
        checkOutput("drain_level_0", level, 8'd0);
        checkOutput("drain_done", {7'd0, drained}, 8'd1);
        step(5);
        checkOutput("spin_before", {7'd0, spin_timeout}, 8'd0);
        step(1);
        checkOutput("spin_set", {7'd0, spin_timeout}, 8'd1);
        step(2);
        checkOutput("drain_sat", level, 8'd0);
        applyStimulus(0, 1, 0, 0, 0, 0);
        step(1);
        checkOutput("spin_clear", {7'd0, spin_timeout}, 8'd0);
        checkOutput("no_fault_yet", {7'd0, fault}, 8'd0);

        applyStimulus(0, 1, 0, 1, 1, 0);
        step(1);
        checkOutput("both_valves_level", level, 8'd0);
        checkOutput("both_valves_fault", {7'd0, fault}, 8'd1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        step(3);
        checkOutput("fault_sticky", {7'd0, fault}, 8'd1);
        applyStimulus(1, 1, 0, 0, 0, 0);
        step(1);
        checkOutput("fault_reset", {7'd0, fault}, 8'd0);
        applyStimulus(0, 0, 1, 0, 0, 0);
        step(1);
        checkOutput("unlocked_motor_fault", {7'd0, fault}, 8'd1);

        applyStimulus(1, 1, 0, 0, 0, 0);
        step(1);
        applyStimulus(0, 1, 1, 0, 0, 0);
        step(2);
        applyStimulus(0, 1, 1, 1, 0, 0);
        step(5);
        checkOutput("mid_level", level, 8'd5);
        checkOutput("mid_cyc", {7'd0, cycle_timeout}, 8'd0);
        step(3);
        checkOutput("mid_cyc_after3", {7'd0, cycle_timeout}, 8'd1);
        applyStimulus(1, 0, 1, 1, 0, 0);
        step(1);
        checkOutput("midrst_level", level, 8'd0);
        checkOutput("midrst_drained", {7'd0, drained}, 8'd1);
        checkOutput("midrst_cyc", {7'd0, cycle_timeout}, 8'd0);
        checkOutput("midrst_spin", {7'd0, spin_timeout}, 8'd0);
        checkOutput("midrst_fault", {7'd0, fault}, 8'd0);
        applyStimulus(0, 1, 0, 1, 0, 0);
        step(1);
        checkOutput("resume_level", level, 8'd1);

        applyStimulus(1, 1, 0, 0, 0, 0);
        step(1);
        applyStimulus(0, 1, 0, 0, 0, 0);
        d4_fill = 1'b1;
        step(3);
        checkOutput("div4_level_0", d4_level, 8'd0);
        step(1);
        checkOutput("div4_level_1", d4_level, 8'd1);
        step(3);
        checkOutput("div4_hold_1", d4_level, 8'd1);
        step(1);
        checkOutput("div4_level_2", d4_level, 8'd2);
        checkOutput("div4_fault", {7'd0, d4_fault}, 8'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
